dcp_mode_decide: RTL and testbench

Parametrised DC/planar override stage for the H.265 intra pre-decision path. It accumulates per-sample gradient energy |gx|+|gy| over 8x8 blocks from the gradient engine and folds the totals up a Z-order quad-tree to 16x16, 32x32, … (`NUM_LVL` levels). For each level it takes the angular search's best mode and cost and emits the final mode per block: DC for flat blocks, planar when the angular cost is poor relative to energy, otherwise the angular mode. It sits between the gradient/angular search units and the mode-candidate FIFO.

---
 rtl/dcp_mode_decide.sv | 259 +++++++++++++++++++++++++
 tb/tb_dcp_mode_decide.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcp_mode_decide.sv
// ---------------------------------------------------------------------------
// dcp_mode_decide
//
// DC/planar override stage of the H.265 intra pre-decision path.
// Per-sample gradient energy |gx|+|gy| is accumulated over 8x8 blocks
// (level 0) and folded up a Z-order quad-tree (level k covers (8<<k)^2
// pixels). When the angular search reports its best mode/cost for a level
// that holds a pending energy, the final mode is decided:
//   energy below the level threshold            -> DC (1)
//   cost above PLAN_MUL * energy                -> planar (0)
//   otherwise                                   -> the angular mode
//
// Optional feature: define DCP_STATS_EN to add saturating decision-class
// counters (cnt_dc, cnt_plan, cnt_ang).
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   clear              synchronous clear of all state (highest priority)
//   g_valid/gx/gy      gradient sample stream (signed GW-bit gradients)
//   g_last             marks the 64th sample of a block (ignored w/o g_valid)
//   ang_valid/ang_lvl  angular result strobe and its tree level
//   ang_mode/ang_cost  best angular mode and its cost
//   ang_ready          bit k: level k holds a pending energy
//   dec_valid/dec_lvl/dec_mode  one-cycle registered decision
//   err_ovf            sticky: pending energy overwritten before use
//   err_orph           sticky: angular result with nothing pending
//
// Handshake: g_valid and ang_valid are plain qualifiers with no back-pressure;
// a sample or result is taken on every rising clock edge where its valid is
// high. ang_ready is advisory status only - a result sent while its bit is
// low is dropped and flagged through err_orph.
// ---------------------------------------------------------------------------
module dcp_mode_decide #(
  parameter int GW       = 11,
  parameter int NUM_LVL  = 3,
  parameter int ACC_W    = 18,
  parameter int COST_W   = 26,
  parameter int DC_TH    = 288,
  parameter int PLAN_MUL = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clear,
  input  logic                 g_valid,
  input  logic signed [GW-1:0] gx,
  input  logic signed [GW-1:0] gy,
  input  logic                 g_last,
  input  logic                 ang_valid,
  input  logic [1:0]           ang_lvl,
  input  logic [5:0]           ang_mode,
  input  logic [COST_W-1:0]    ang_cost,
  output logic [NUM_LVL-1:0]   ang_ready,
  output logic                 dec_valid,
  output logic [1:0]           dec_lvl,
  output logic [5:0]           dec_mode,
  output logic                 err_ovf,
  output logic                 err_orph
`ifdef DCP_STATS_EN
  ,
  output logic [15:0]          cnt_dc,
  output logic [15:0]          cnt_plan,
  output logic [15:0]          cnt_ang
`endif
);

  // EW: one extra bit so |-2^(GW-1)| and the sum of two such values are exact.
  localparam int EW = GW + 1;
  // All levels share the widest (top-level) energy width.
  localparam int NW = ACC_W + 2 * (NUM_LVL - 1);
  localparam int ZW = (NUM_LVL > 1) ? 2 * (NUM_LVL - 1) : 2;
  localparam int DW = (NUM_LVL > 1) ? NUM_LVL - 1 : 1;

  // Stage A
  logic signed [EW-1:0] w_gx_s, w_gy_s;
  logic [EW-1:0]        w_ax, w_ay, w_e;
  logic                 r_e_vld, r_e_last;
  logic [EW-1:0]        r_e;

  // Tree state
  logic [NW-1:0]        r_acc [NUM_LVL];
  logic [NW-1:0]        r_nrg [NUM_LVL];
  logic [NUM_LVL-1:0]   r_pend;
  // Z-order index: field k-1 (bits 2k-1:2k-2) is the child position of the
  // next block entering level k. Each field advances when its level accepts
  // a child, so together they count level-0 blocks modulo 4^(NUM_LVL-1).
  logic [ZW-1:0]        r_zidx;
  // r_done[k]: level k completed on the previous edge; level k+1 folds it now.
  logic [DW-1:0]        r_done;

  logic [NW-1:0]        w_sum [NUM_LVL];
  logic [NUM_LVL-1:0]   w_cmp;
  logic [NUM_LVL-1:0]   w_clr;

  // Decision
  logic                 w_lvl_ok, w_pend_sel, w_hit;
  logic [NW-1:0]        w_sel;
  logic [63:0]          w_th, w_prod;
  logic                 w_is_dc, w_is_plan;
  logic [5:0]           w_mode;

  logic                 r_dec_valid;
  logic [1:0]           r_dec_lvl;
  logic [5:0]           r_dec_mode;
  logic                 r_err_ovf, r_err_orph;
`ifdef DCP_STATS_EN
  logic [15:0]          r_cnt_dc, r_cnt_plan, r_cnt_ang;
`endif

  // ---------------- stage A: absolute gradients ----------------
  always_comb begin
    w_gx_s = {gx[GW-1], gx};
    w_gy_s = {gy[GW-1], gy};
    w_ax   = w_gx_s[EW-1] ? EW'(-w_gx_s) : EW'(w_gx_s);
    w_ay   = w_gy_s[EW-1] ? EW'(-w_gy_s) : EW'(w_gy_s);
    w_e    = w_ax + w_ay;
  end

  // ---------------- tree sums and completions ----------------
  always_comb begin
    w_cmp = '0;
    for (int k = 0; k < NUM_LVL; k++) w_sum[k] = '0;
    w_sum[0] = r_acc[0] + NW'(r_e);
    w_cmp[0] = r_e_vld & r_e_last;
    for (int k = 1; k < NUM_LVL; k++) begin
      // First child loads, children 2..4 add; 4th child completes the level.
      w_sum[k] = ((r_zidx[2*k-1 -: 2] == 2'd0) ? '0 : r_acc[k]) + r_nrg[k-1];
      w_cmp[k] = r_done[k-1] & (r_zidx[2*k-1 -: 2] == 2'd3);
    end
  end

  // ---------------- decision ----------------
  always_comb begin
    w_sel      = '0;
    w_pend_sel = 1'b0;
    for (int k = 0; k < NUM_LVL; k++) begin
      if (ang_lvl == 2'(k)) begin
        w_sel      = r_nrg[k];
        w_pend_sel = r_pend[k];
      end
    end
    w_lvl_ok = int'({30'd0, ang_lvl}) < NUM_LVL;
    w_hit    = ang_valid & w_lvl_ok & w_pend_sel;
    w_clr    = '0;
    for (int k = 0; k < NUM_LVL; k++) w_clr[k] = w_hit & (ang_lvl == 2'(k));
    // Threshold and planar product are evaluated at 64 bits so neither wraps.
    w_th      = 64'(DC_TH) << {ang_lvl, 1'b0};
    w_prod    = 64'(PLAN_MUL) * 64'(w_sel);
    w_is_dc   = 64'(w_sel) < w_th;
    w_is_plan = 64'(ang_cost) > w_prod;
    if (w_is_dc)        w_mode = 6'd1;
    else if (w_is_plan) w_mode = 6'd0;
    else                w_mode = ang_mode;
  end

  // ---------------- state ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_e_vld  <= 1'b0;
      r_e_last <= 1'b0;
      r_e      <= '0;
      for (int k = 0; k < NUM_LVL; k++) begin
        r_acc[k] <= '0;
        r_nrg[k] <= '0;
      end
      r_pend      <= '0;
      r_zidx      <= '0;
      r_done      <= '0;
      r_dec_valid <= 1'b0;
      r_dec_lvl   <= '0;
      r_dec_mode  <= '0;
      r_err_ovf   <= 1'b0;
      r_err_orph  <= 1'b0;
`ifdef DCP_STATS_EN
      r_cnt_dc    <= '0;
      r_cnt_plan  <= '0;
      r_cnt_ang   <= '0;
`endif
    end else if (clear) begin
      r_e_vld  <= 1'b0;
      r_e_last <= 1'b0;
      r_e      <= '0;
      for (int k = 0; k < NUM_LVL; k++) begin
        r_acc[k] <= '0;
        r_nrg[k] <= '0;
      end
      r_pend      <= '0;
      r_zidx      <= '0;
      r_done      <= '0;
      r_dec_valid <= 1'b0;
      r_dec_lvl   <= '0;
      r_dec_mode  <= '0;
      r_err_ovf   <= 1'b0;
      r_err_orph  <= 1'b0;
`ifdef DCP_STATS_EN
      r_cnt_dc    <= '0;
      r_cnt_plan  <= '0;
      r_cnt_ang   <= '0;
`endif
    end else begin
      // stage A
      r_e_vld  <= g_valid;
      r_e_last <= g_valid & g_last;
      if (g_valid) r_e <= w_e;

      // level 0
      if (r_e_vld) r_acc[0] <= w_cmp[0] ? '0 : w_sum[0];
      if (w_cmp[0]) r_nrg[0] <= w_sum[0];

      // levels 1.. fold the child completed on the previous edge
      for (int k = 1; k < NUM_LVL; k++) begin
        if (r_done[k-1]) begin
          r_zidx[2*k-1 -: 2] <= r_zidx[2*k-1 -: 2] + 2'd1;
          r_acc[k]           <= w_cmp[k] ? '0 : w_sum[k];
          if (w_cmp[k]) r_nrg[k] <= w_sum[k];
        end
      end
      for (int k = 0; k < NUM_LVL - 1; k++) r_done[k] <= w_cmp[k];

      // A consume in the same cycle as a completion reads the old energy
      // and frees the slot, so the new value is not an overwrite.
      for (int k = 0; k < NUM_LVL; k++) begin
        r_pend[k] <= w_cmp[k] | (r_pend[k] & ~w_clr[k]);
        if (w_cmp[k] & r_pend[k] & ~w_clr[k]) r_err_ovf <= 1'b1;
      end

      r_dec_valid <= w_hit;
      if (w_hit) begin
        r_dec_lvl  <= ang_lvl;
        r_dec_mode <= w_mode;
      end
      if (ang_valid & ~w_hit) r_err_orph <= 1'b1;

`ifdef DCP_STATS_EN
      if (w_hit) begin
        if (w_is_dc) begin
          if (r_cnt_dc != 16'hFFFF) r_cnt_dc <= r_cnt_dc + 16'd1;
        end else if (w_is_plan) begin
          if (r_cnt_plan != 16'hFFFF) r_cnt_plan <= r_cnt_plan + 16'd1;
        end else begin
          if (r_cnt_ang != 16'hFFFF) r_cnt_ang <= r_cnt_ang + 16'd1;
        end
      end
`endif
    end
  end

  assign ang_ready = r_pend;
  assign dec_valid = r_dec_valid;
  assign dec_lvl   = r_dec_lvl;
  assign dec_mode  = r_dec_mode;
  assign err_ovf   = r_err_ovf;
  assign err_orph  = r_err_orph;
`ifdef DCP_STATS_EN
  assign cnt_dc    = r_cnt_dc;
  assign cnt_plan  = r_cnt_plan;
  assign cnt_ang   = r_cnt_ang;
`endif

endmodule

// File: tb/tb_dcp_mode_decide.sv
// ---------------------------------------------------------------------------
// Testbench for dcp_mode_decide (default parameters). Directed scenarios
// followed by randomized blocks and queries, checked against a model that
// sums per-block energies into aligned groups of 4^k blocks.
// ---------------------------------------------------------------------------
module tb_dcp_mode_decide;
  localparam int GW       = 11;
  localparam int NUM_LVL  = 3;
  localparam int ACC_W    = 18;
  localparam int COST_W   = 26;
  localparam int DC_TH    = 288;
  localparam int PLAN_MUL = 32;
  localparam longint COST_MAX = (64'd1 << COST_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  logic                 g_valid = 1'b0;
  logic signed [GW-1:0] gx = '0;
  logic signed [GW-1:0] gy = '0;
  logic                 g_last = 1'b0;
  logic                 ang_valid = 1'b0;
  logic [1:0]           ang_lvl = '0;
  logic [5:0]           ang_mode = '0;
  logic [COST_W-1:0]    ang_cost = '0;
  logic [NUM_LVL-1:0]   ang_ready;
  logic                 dec_valid;
  logic [1:0]           dec_lvl;
  logic [5:0]           dec_mode;
  logic                 err_ovf;
  logic                 err_orph;
`ifdef DCP_STATS_EN
  logic [15:0]          cnt_dc, cnt_plan, cnt_ang;
`endif

  dcp_mode_decide #(
    .GW(GW), .NUM_LVL(NUM_LVL), .ACC_W(ACC_W), .COST_W(COST_W),
    .DC_TH(DC_TH), .PLAN_MUL(PLAN_MUL)
  ) dut (
    .clk(clk), .rstn(rstn), .clear(clear),
    .g_valid(g_valid), .gx(gx), .gy(gy), .g_last(g_last),
    .ang_valid(ang_valid), .ang_lvl(ang_lvl), .ang_mode(ang_mode),
    .ang_cost(ang_cost), .ang_ready(ang_ready),
    .dec_valid(dec_valid), .dec_lvl(dec_lvl), .dec_mode(dec_mode),
    .err_ovf(err_ovf), .err_orph(err_orph)
`ifdef DCP_STATS_EN
    , .cnt_dc(cnt_dc), .cnt_plan(cnt_plan), .cnt_ang(cnt_ang)
`endif
  );

  // ---------------- scoreboard / model ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] exp_q[$];   // {valid, lvl, mode}

  longint m_blk_e;
  int     m_blocks;
  longint m_grp [NUM_LVL];
  longint m_nrg [NUM_LVL];
  bit     m_pend [NUM_LVL];
  bit     m_ovf, m_orph;
  int     m_cdc, m_cpl, m_cang;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic longint iabs(input int v);
    return (v < 0) ? -longint'(v) : longint'(v);
  endfunction

  task automatic model_reset();
    m_blk_e = 0; m_blocks = 0; m_ovf = 0; m_orph = 0;
    m_cdc = 0; m_cpl = 0; m_cang = 0;
    for (int k = 0; k < NUM_LVL; k++) begin
      m_grp[k] = 0; m_nrg[k] = 0; m_pend[k] = 0;
    end
  endtask

  // A finished 8x8 block contributes to the group of 4^k blocks it belongs to
  // on every level; a group is complete once 4^k blocks have been seen.
  task automatic model_complete();
    m_blocks++;
    for (int k = 0; k < NUM_LVL; k++) begin
      m_grp[k] += m_blk_e;
      if (m_blocks % (1 << (2 * k)) == 0) begin
        if (m_pend[k]) m_ovf = 1;
        m_pend[k] = 1;
        m_nrg[k]  = m_grp[k];
        m_grp[k]  = 0;
      end
    end
    m_blk_e = 0;
  endtask

  function automatic logic [NUM_LVL-1:0] model_ready();
    logic [NUM_LVL-1:0] v;
    for (int k = 0; k < NUM_LVL; k++) v[k] = m_pend[k];
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    model_reset();
  endtask

  task automatic drive_samp(input int x, input int y, input bit last);
    g_valid = 1'b1; gx = GW'(x); gy = GW'(y); g_last = last;
    tick(1);
    g_valid = 1'b0; g_last = 1'b0;
    m_blk_e += iabs(x) + iabs(y);
  endtask

  task automatic block(input int x, input int y);
    for (int i = 0; i < 64; i++) drive_samp(x, y, i == 63);
    model_complete();
  endtask

  task automatic check_state(input string tag);
    check({tag, ".ang_ready"}, 64'(ang_ready), 64'(model_ready()));
    check({tag, ".err_ovf"}, 64'(err_ovf), 64'(m_ovf));
    check({tag, ".err_orph"}, 64'(err_orph), 64'(m_orph));
  endtask

  task automatic query(input int lvl, input int mode, input longint cost);
    logic [8:0] e;
    logic [5:0] md;
    if (lvl < NUM_LVL && m_pend[lvl]) begin
      if (m_nrg[lvl] < (longint'(DC_TH) << (2 * lvl))) begin
        md = 6'd1; m_cdc++;
      end else if (cost > longint'(PLAN_MUL) * m_nrg[lvl]) begin
        md = 6'd0; m_cpl++;
      end else begin
        md = 6'(mode); m_cang++;
      end
      m_pend[lvl] = 0;
      e = {1'b1, 2'(lvl), md};
    end else begin
      m_orph = 1;
      e = {1'b0, 2'(lvl), 6'd0};
    end
    exp_q.push_back(e);
    ang_valid = 1'b1; ang_lvl = 2'(lvl); ang_mode = 6'(mode); ang_cost = COST_W'(cost);
    tick(1);
    ang_valid = 1'b0;
    e = exp_q.pop_front();
    check($sformatf("dec_valid.l%0d", lvl), 64'(dec_valid), 64'(e[8]));
    if (e[8]) begin
      check($sformatf("dec_lvl.l%0d", lvl), 64'(dec_lvl), 64'(e[7:6]));
      check($sformatf("dec_mode.l%0d", lvl), 64'(dec_mode), 64'(e[5:0]));
    end
    check("err_orph.q", 64'(err_orph), 64'(m_orph));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    tick(3);
    rstn = 1'b1;
    tick(1);

    // reset state
    check("rst.ang_ready", 64'(ang_ready), 64'd0);
    check("rst.dec_valid", 64'(dec_valid), 64'd0);
    check("rst.dec_lvl", 64'(dec_lvl), 64'd0);
    check("rst.dec_mode", 64'(dec_mode), 64'd0);
    check("rst.err_ovf", 64'(err_ovf), 64'd0);
    check("rst.err_orph", 64'(err_orph), 64'd0);

    // flat block -> DC; planar boundary on the 320-energy block
    block(2, 2); tick(5); check_state("flat");
    query(0, 18, 100);
    block(5, 0); tick(5);
    query(0, 18, 10241);
    block(5, 0); tick(5);
    query(0, 18, 10240);

    // quad fold: 16 blocks of 320
    do_clear();
    for (int b = 0; b < 16; b++) begin
      block(5, 0);
      if (b == 15) begin
        tick(2);
        check("fold.ready2_early", 64'(ang_ready[2]), 64'd0);
        check("fold.ready1", 64'(ang_ready[1]), 64'd1);
        tick(1);
        check("fold.ready2", 64'(ang_ready[2]), 64'd1);
        tick(2);
      end else begin
        tick(5);
      end
      query(0, 18, 100);
      if (b % 4 == 3) query(1, 22, 40961);
      if (b == 15) query(2, 26, 163840);
    end
    check_state("fold");

    // extremes: -1024/-1024 everywhere
    do_clear();
    for (int b = 0; b < 16; b++) begin
      block(-1024, -1024); tick(5);
      query(0, 10, 4194305);
      if (b % 4 == 3) query(1, 34, 16777216);
      if (b == 15) query(2, 50, COST_MAX);
    end
    check_state("ext");

    // errors: overwrite and orphans
    do_clear();
    block(5, 0); tick(5);
    block(5, 0); tick(5);
    check_state("ovf");
    query(1, 18, 100);
    query(3, 18, 100);
    check_state("orph");

    // same-cycle consume and completion on level 0
    do_clear();
    block(2, 2); tick(5);
    for (int i = 0; i < 64; i++) drive_samp(5, 0, i == 63);
    query(0, 18, 100);
    model_complete();
    tick(5);
    check_state("same");
    query(0, 18, 100);

    // randomized blocks with sample gaps and stray g_last
    do_clear();
    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < 64; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          g_last = 1'(($urandom_range(0, 1)));
          tick($urandom_range(1, 3));
          g_last = 1'b0;
        end
        drive_samp(int'($urandom_range(0, 16)) - 8, int'($urandom_range(0, 16)) - 8, i == 63);
      end
      model_complete();
      tick(5);
      check_state("rnd");
      repeat ($urandom_range(0, 2)) begin
        int lv;
        longint c;
        lv = int'($urandom_range(0, 3));
        if (lv < NUM_LVL && m_pend[lv]) begin
          c = 64 * m_nrg[lv] + 16;
          if (c > COST_MAX) c = COST_MAX;
          c = longint'($urandom_range(32'(c), 0));
        end else begin
          c = longint'($urandom_range(0, 1000));
        end
        query(lv, int'($urandom_range(2, 34)), c);
      end
    end

    // reset in the middle of a block, zidx nonzero beforehand
    do_clear();
    block(5, 0); tick(5);
    block(5, 0); tick(5);
    for (int i = 0; i < 30; i++) drive_samp(7, 7, 1'b0);
    do_reset();
    tick(1);
    check_state("rstmid");
    for (int b = 0; b < 4; b++) begin
      block(5, 0); tick(5);
      if (b == 0) query(0, 18, 10241);
    end
    check_state("rstmid.fold");
    query(1, 22, 40961);
    query(0, 18, 10240);

`ifdef DCP_STATS_EN
    check("cnt_dc", 64'(cnt_dc), 64'(m_cdc));
    check("cnt_plan", 64'(cnt_plan), 64'(m_cpl));
    check("cnt_ang", 64'(cnt_ang), 64'(m_cang));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
